// File: rtl/fetch_ctl_pkg.sv
// Shared types and defaults for the fetch controller and its instruction buffer.
package fetch_ctl_pkg;

  localparam int unsigned PC_W                = 64;
  localparam int unsigned INSTR_W             = 32;
  localparam int unsigned IBUF_DEPTH_DEF      = 4;
  localparam int unsigned MAX_OUTSTANDING_DEF = 2;

  typedef logic [INSTR_W-1:0] t_rv_instr;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } t_fetch_state;

  // One buffered instruction: the PC it was fetched from and the raw word.
  typedef struct packed {
    logic [PC_W-1:0] pc;
    t_rv_instr       instr;
  } t_ibuf_entry;

  // Packet handed to decode.
  typedef struct packed {
    logic [PC_W-1:0] pc;
    t_rv_instr       instr;
  } t_instr_pkt;

  // Force a PC onto a word boundary.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return pc & ~PC_W'(3);
  endfunction

endpackage

// File: rtl/fetch_ctl_if.sv
// Icache request/response and decode delivery signals of the fetch controller.
interface fetch_ctl_if;
  import fetch_ctl_pkg::*;

  logic            ic_req_valid;
  logic            ic_req_ready;
  logic [PC_W-1:0] ic_req_addr;
  logic            ic_rsp_valid;
  t_rv_instr       ic_rsp_data;
  logic            valid_fe1;
  t_instr_pkt      instr_fe1;
  logic            decode_ready_de0;

  modport master (
    output ic_req_valid, ic_req_addr, valid_fe1, instr_fe1,
    input  ic_req_ready, ic_rsp_valid, ic_rsp_data, decode_ready_de0
  );

  modport slave (
    input  ic_req_valid, ic_req_addr, valid_fe1, instr_fe1,
    output ic_req_ready, ic_rsp_valid, ic_rsp_data, decode_ready_de0
  );

endinterface

// File: rtl/fetch_ctl_gen_fifo.sv
// Generic FIFO with show-ahead head, synchronous clear and async reset.
module fetch_ctl_gen_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointer advance with wrap at DEPTH.
  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy tracking; clear drops every entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage write; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_ctl.sv
// Fetch controller: sequential PC generation, icache request credits, stale
// response dropping after a nuke, and the instruction buffer feeding decode.
module fetch_ctl
  import fetch_ctl_pkg::*;
#(
  parameter int unsigned     IBUF_DEPTH      = IBUF_DEPTH_DEF,
  parameter int unsigned     MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
  parameter logic [PC_W-1:0] RESET_PC        = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            nuke_valid_rb1,
  input  logic [PC_W-1:0] nuke_pc_rb1,
  input  logic            resume_fetch_rbx,
  fetch_ctl_if.master     bus
);

  localparam int unsigned IB_CW   = $clog2(IBUF_DEPTH + 1);
  localparam int unsigned OUT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned ENTRY_W = $bits(t_ibuf_entry);

  t_fetch_state    state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  logic [OUT_W-1:0] stale_q, stale_d;

  logic             run;
  logic             req_valid;
  logic             req_fire;
  logic             deliver;
  logic             ibuf_push;
  logic             ibuf_pop;
  logic             pcq_push;

  logic [IB_CW-1:0] ibuf_cnt;
  logic             ibuf_empty;
  logic             ibuf_full;
  logic [ENTRY_W-1:0] ibuf_wdata;
  logic [ENTRY_W-1:0] ibuf_rdata;
  t_ibuf_entry      ibuf_in;
  t_ibuf_entry      ibuf_head;

  logic [PC_W-1:0]  pcq_rdata;
  logic             pcq_empty;
  logic             pcq_full;
  logic [OUT_W-1:0] pcq_cnt;

  // Instruction buffer: returned words with their PCs, head presented to decode.
  fetch_ctl_gen_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (IBUF_DEPTH)
  ) u_ibuf (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (nuke_valid_rb1),
    .push    (ibuf_push),
    .wdata   (ibuf_wdata),
    .pop     (ibuf_pop),
    .rdata   (ibuf_rdata),
    .empty   (ibuf_empty),
    .full    (ibuf_full),
    .count   (ibuf_cnt)
  );

  // PC FIFO: address of each accepted request, consumed by its response.
  fetch_ctl_gen_fifo #(
    .WIDTH (PC_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pcq (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (nuke_valid_rb1),
    .push    (pcq_push),
    .wdata   (fetch_pc_q),
    .pop     (ibuf_push),
    .rdata   (pcq_rdata),
    .empty   (pcq_empty),
    .full    (pcq_full),
    .count   (pcq_cnt)
  );

  assign ibuf_in.pc    = pcq_rdata;
  assign ibuf_in.instr = bus.ic_rsp_data;
  assign ibuf_wdata    = ibuf_in;
  assign ibuf_head     = t_ibuf_entry'(ibuf_rdata);

  // State, fetch PC and credit/stale counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= RUN;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      stale_q       <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      stale_q       <= stale_d;
    end
  end

  // Next state, request credit, response routing and delivery; nuke wins all.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    stale_d       = stale_q;
    run           = 1'b0;
    req_valid     = 1'b0;
    req_fire      = 1'b0;
    deliver       = 1'b0;
    ibuf_push     = 1'b0;
    ibuf_pop      = 1'b0;
    pcq_push      = 1'b0;

    run = reset_n && (state_q == RUN) && !nuke_valid_rb1;

    req_valid = run
             && (outstanding_q < OUT_W'(MAX_OUTSTANDING))
             && ((32'(outstanding_q) + 32'(ibuf_cnt)) < IBUF_DEPTH);
    req_fire  = req_valid && bus.ic_req_ready;
    pcq_push  = req_fire;

    deliver   = run && !ibuf_empty;
    ibuf_pop  = deliver && bus.decode_ready_de0;
    ibuf_push = bus.ic_rsp_valid && !nuke_valid_rb1 && (stale_q == '0);

    outstanding_d = outstanding_q + OUT_W'(req_fire) - OUT_W'(bus.ic_rsp_valid);

    if (nuke_valid_rb1) begin
      state_d    = HOLD;
      fetch_pc_d = align_pc(nuke_pc_rb1);
      stale_d    = outstanding_q - OUT_W'(bus.ic_rsp_valid);
    end else begin
      if ((state_q == HOLD) && resume_fetch_rbx) state_d = RUN;
      if (req_fire) fetch_pc_d = fetch_pc_q + PC_W'(4);
      if (bus.ic_rsp_valid && (stale_q != '0)) stale_d = stale_q - OUT_W'(1);
    end
  end

  assign bus.ic_req_valid = req_valid;
  assign bus.ic_req_addr  = fetch_pc_q;
  assign bus.valid_fe1    = deliver;
  assign bus.instr_fe1    = deliver ? t_instr_pkt'{pc: ibuf_head.pc, instr: ibuf_head.instr}
                                    : '0;

`ifndef SYNTHESIS
  logic hold_pend;

  // Remember a presented-but-not-taken packet for the hold check.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hold_pend <= 1'b0;
    else          hold_pend <= deliver && !bus.decode_ready_de0;
  end

  // Protocol and bookkeeping invariants.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      a_rsp_credit: assert (!(bus.ic_rsp_valid && (outstanding_q == '0)));
      a_pc_align:   assert (!(deliver && (bus.instr_fe1.pc[1:0] != 2'b00)));
      a_hold:       assert (!hold_pend || deliver || nuke_valid_rb1);
      a_ibuf_ovf:   assert (!(ibuf_push && ibuf_full));
      a_pcq:        assert (!(pcq_push && pcq_full) && !(ibuf_push && pcq_empty));
      a_credit_sum: assert ((32'(pcq_cnt) + 32'(stale_q)) == 32'(outstanding_q));
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctl.sv
// Directed vector bench for fetch_ctl: per-cycle stimulus rows with
// hand-computed outputs, plus an asynchronous mid-stream reset sequence.
module tb_fetch_ctl;
  import fetch_ctl_pkg::*;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            nuke_valid_rb1;
  logic [PC_W-1:0] nuke_pc_rb1;
  logic            resume_fetch_rbx;

  fetch_ctl_if bus ();

  fetch_ctl #(
    .IBUF_DEPTH      (4),
    .MAX_OUTSTANDING (2),
    .RESET_PC        (64'h0)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .nuke_valid_rb1   (nuke_valid_rb1),
    .nuke_pc_rb1      (nuke_pc_rb1),
    .resume_fetch_rbx (resume_fetch_rbx),
    .bus              (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        nk;
    logic [63:0] npc;
    logic        res;
    logic        rdy;
    logic        rv;
    logic [63:0] rpc;
    logic        dec;
    logic        erv;
    logic [63:0] ea;
    logic        ev;
    logic [63:0] epc;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Icache content model: instruction word stored at a given PC.
  function automatic logic [31:0] ins(input logic [63:0] pc);
    return 32'h00C0_0013 ^ pc[31:0] ^ pc[63:32];
  endfunction

  task automatic v(input logic nk, input logic [63:0] npc, input logic res,
                   input logic rdy, input logic rv, input logic [63:0] rpc,
                   input logic dec, input logic erv, input logic [63:0] ea,
                   input logic ev, input logic [63:0] epc);
    vec_t t;
    t.nk = nk; t.npc = npc; t.res = res; t.rdy = rdy; t.rv = rv; t.rpc = rpc;
    t.dec = dec; t.erv = erv; t.ea = ea; t.ev = ev; t.epc = epc;
    vq.push_back(t);
  endtask

  task automatic chk(input string name, input logic [191:0] got, input logic [191:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [191:0] outs();
    return 192'({bus.ic_req_valid, bus.ic_req_addr, bus.valid_fe1, bus.instr_fe1});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    t_instr_pkt epkt;

    // Columns: nuke npc resume rdy rsp_v rsp_pc dec | req_v addr valid pc
    // Streaming with 1-cycle icache, then decode stalls with head pc=0x10.
    v(0,0,0,1,0,'h0,  1, 1,'h0,  0,'h0);
    v(0,0,0,1,1,'h0,  1, 1,'h4,  0,'h0);
    v(0,0,0,1,1,'h4,  1, 1,'h8,  1,'h0);
    v(0,0,0,1,1,'h8,  1, 1,'hc,  1,'h4);
    v(0,0,0,1,1,'hc,  1, 1,'h10, 1,'h8);
    v(0,0,0,1,1,'h10, 1, 1,'h14, 1,'hc);
    v(0,0,0,1,1,'h14, 0, 1,'h18, 1,'h10);
    v(0,0,0,1,1,'h18, 0, 1,'h1c, 1,'h10);
    v(0,0,0,1,1,'h1c, 0, 0,'h20, 1,'h10);
    for (int i = 0; i < 7; i++) v(0,0,0,1,0,'h0, 0, 0,'h20, 1,'h10);
    // Decode resumes: drain in order while refilling.
    v(0,0,0,1,0,'h0,  1, 0,'h20, 1,'h10);
    v(0,0,0,1,0,'h0,  1, 1,'h20, 1,'h14);
    v(0,0,0,1,1,'h20, 1, 1,'h24, 1,'h18);
    v(0,0,0,1,1,'h24, 1, 1,'h28, 1,'h1c);
    v(0,0,0,1,1,'h28, 1, 1,'h2c, 1,'h20);
    v(0,0,0,1,0,'h0,  1, 1,'h30, 1,'h24);
    // Nuke with two requests in flight; both responses dropped.
    v(1,'h800,0,1,0,'h0,  1, 0,'h34,  0,'h0);
    v(0,0,0,1,1,'h2c,     1, 0,'h800, 0,'h0);
    v(0,0,0,1,1,'h30,     1, 0,'h800, 0,'h0);
    v(0,0,1,1,0,'h0,      1, 0,'h800, 0,'h0);
    v(0,0,0,1,0,'h0,      1, 1,'h800, 0,'h0);
    v(0,0,0,1,1,'h800,    1, 1,'h804, 0,'h0);
    v(0,0,0,1,1,'h804,    1, 1,'h808, 1,'h800);
    v(0,0,0,1,0,'h0,      0, 1,'h80c, 1,'h804);
    // Nuke together with a response and a ready decode: one stale left.
    v(1,'h1000,0,1,1,'h808, 1, 0,'h810,  0,'h0);
    v(0,0,1,1,0,'h0,        1, 0,'h1000, 0,'h0);
    v(0,0,0,1,0,'h0,        1, 1,'h1000, 0,'h0);
    v(0,0,0,1,1,'h80c,      1, 0,'h1004, 0,'h0);
    v(0,0,0,1,1,'h1000,     1, 1,'h1004, 0,'h0);
    v(0,0,0,1,1,'h1004,     1, 1,'h1008, 1,'h1000);
    // Nuke and resume in the same cycle: nuke wins, second resume restarts.
    v(1,'h2000,1,1,1,'h1008, 1, 0,'h100c, 0,'h0);
    v(0,0,0,1,0,'h0,         1, 0,'h2000, 0,'h0);
    v(0,0,1,1,0,'h0,         1, 0,'h2000, 0,'h0);
    v(0,0,0,1,0,'h0,         1, 1,'h2000, 0,'h0);
    v(0,0,0,0,1,'h2000,      1, 1,'h2004, 0,'h0);
    v(0,0,0,0,0,'h0,         1, 1,'h2004, 1,'h2000);

    reset_n              = 1'b0;
    nuke_valid_rb1       = 1'b0;
    nuke_pc_rb1          = '0;
    resume_fetch_rbx     = 1'b0;
    bus.ic_req_ready     = 1'b0;
    bus.ic_rsp_valid     = 1'b0;
    bus.ic_rsp_data      = '0;
    bus.decode_ready_de0 = 1'b0;

    @(negedge clk);
    @(negedge clk);
    #1 chk("reset_outs", outs(), '0);
    reset_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      nuke_valid_rb1       = vq[i].nk;
      nuke_pc_rb1          = vq[i].npc;
      resume_fetch_rbx     = vq[i].res;
      bus.ic_req_ready     = vq[i].rdy;
      bus.ic_rsp_valid     = vq[i].rv;
      bus.ic_rsp_data      = ins(vq[i].rpc);
      bus.decode_ready_de0 = vq[i].dec;
      epkt = '0;
      if (vq[i].ev) begin
        epkt.pc    = vq[i].epc;
        epkt.instr = ins(vq[i].epc);
      end
      #1 chk($sformatf("vec%0d", i), outs(),
             192'({vq[i].erv, vq[i].ea, vq[i].ev, epkt}));
    end

    // Asynchronous reset while a response is arriving mid-stream.
    @(negedge clk);
    nuke_valid_rb1 = 1'b0; resume_fetch_rbx = 1'b0;
    bus.ic_req_ready = 1'b1; bus.ic_rsp_valid = 1'b0; bus.decode_ready_de0 = 1'b1;
    #1 chk("pre_rst_req", 192'({bus.ic_req_valid, bus.ic_req_addr}), 192'({1'b1, 64'h2004}));
    @(negedge clk);
    bus.ic_rsp_valid = 1'b1; bus.ic_rsp_data = ins(64'h2004);
    #2 reset_n = 1'b0;
    #1 chk("rst_async_outs", outs(), '0);
    @(negedge clk);
    bus.ic_rsp_valid = 1'b0;
    reset_n = 1'b1;
    #1 chk("rst_first_req", 192'({bus.ic_req_valid, bus.ic_req_addr, bus.valid_fe1}),
           192'({1'b1, 64'h0, 1'b0}));
    @(negedge clk);
    bus.ic_rsp_valid = 1'b1; bus.ic_rsp_data = ins(64'h0);
    #1 chk("rst_second_req", 192'({bus.ic_req_valid, bus.ic_req_addr, bus.valid_fe1}),
           192'({1'b1, 64'h4, 1'b0}));
    @(negedge clk);
    bus.ic_rsp_valid = 1'b1; bus.ic_rsp_data = ins(64'h4);
    #1 chk("rst_deliver", 192'({bus.valid_fe1, bus.instr_fe1}),
           192'({1'b1, 64'h0, ins(64'h0)}));
    @(negedge clk);
    bus.ic_rsp_valid = 1'b0; bus.ic_req_ready = 1'b0; bus.decode_ready_de0 = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
